// File: rtl/frame_dump_pkg.sv
// Shared types and constants for the preview framebuffer dump sequencer.
// Header layout: two sync bytes, then the frame width and height.
package frame_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    LATCH,
    SEND,
    NEXT,
    DONE
  } dump_state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  function automatic logic [7:0] header_byte(input logic [1:0] idx,
                                             input logic [7:0] width,
                                             input logic [7:0] height);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC0;
      2'd1:    b = SYNC1;
      2'd2:    b = width;
      default: b = height;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser plus low-time qualifier: a press only counts after the
// synchronised button has been released for a full saturated count.
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pressed
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

  logic                     sync_q1;
  logic                     sync_q2;
  logic [DEBOUNCE_BITS-1:0] low_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      low_count <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2) begin
        low_count <= '0;
      end else if (!(&low_count)) begin
        low_count <= low_count + CNT_ONE;
      end
    end
  end

  // The counter clears on the cycle after the press, so this is a single pulse.
  assign pressed = sync_q2 && (&low_count);

endmodule

// File: rtl/frame_dump_ctrl.sv
// Streams a header and the whole preview framebuffer (raster order, each word
// MSB first) to the debug UART, pacing every byte against busy plus a holdoff.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int WIDTH         = 40,
  parameter int HEIGHT        = 30,
  parameter int HOLDOFF_BITS  = 13,
  parameter int DEBOUNCE_BITS = 14
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        btn_i,
  input  logic        start_i,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_q,
  input  logic        uart_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [5:0]              X_LAST   = 6'(WIDTH - 1);
  localparam logic [4:0]              Y_LAST   = 5'(HEIGHT - 1);
  localparam logic [7:0]              HDR_W    = 8'(WIDTH);
  localparam logic [7:0]              HDR_H    = 8'(HEIGHT);
  localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE = HOLDOFF_BITS'(1);

  dump_state_t             state, state_nxt;
  logic [5:0]              x_nxt;
  logic [4:0]              y_nxt;
  logic [1:0]              hdr_idx, hdr_idx_nxt;
  logic [1:0]              byte_idx, byte_idx_nxt;
  logic [31:0]             shreg, shreg_nxt;
  logic                    wr_nxt;
  logic [7:0]              dat_nxt;
  logic                    done_nxt;
  logic [HOLDOFF_BITS-1:0] holdoff;
  logic                    btn_pressed;
  logic                    trigger;
  logic                    ready;

  btn_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_btn_debounce (
    .clk    (sys_clk_i),
    .rst    (sys_rst_i),
    .raw    (btn_i),
    .pressed(btn_pressed)
  );

  // Counts consecutive quiet cycles; any strobe or UART activity restarts it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || uart_busy_i || uart_wr_o) begin
      holdoff <= '0;
    end else if (!(&holdoff)) begin
      holdoff <= holdoff + HOLD_ONE;
    end
  end

  assign ready   = (&holdoff) && !uart_busy_i && !uart_wr_o;
  assign trigger = start_i || btn_pressed;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state      <= IDLE;
      read_x     <= '0;
      read_y     <= '0;
      hdr_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      uart_wr_o  <= 1'b0;
      uart_dat_o <= '0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      read_x     <= x_nxt;
      read_y     <= y_nxt;
      hdr_idx    <= hdr_idx_nxt;
      byte_idx   <= byte_idx_nxt;
      shreg      <= shreg_nxt;
      uart_wr_o  <= wr_nxt;
      uart_dat_o <= dat_nxt;
      done_o     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    x_nxt        = read_x;
    y_nxt        = read_y;
    hdr_idx_nxt  = hdr_idx;
    byte_idx_nxt = byte_idx;
    shreg_nxt    = shreg;
    wr_nxt       = 1'b0;
    dat_nxt      = uart_dat_o;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          hdr_idx_nxt = '0;
          x_nxt       = '0;
          y_nxt       = '0;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        if (ready) begin
          wr_nxt      = 1'b1;
          dat_nxt     = header_byte(hdr_idx, HDR_W, HDR_H);
          hdr_idx_nxt = hdr_idx + 2'd1;
          if (hdr_idx == 2'd3) state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LATCH;
      LATCH: begin
        shreg_nxt    = read_q;
        byte_idx_nxt = '0;
        state_nxt    = SEND;
      end
      SEND: begin
        if (ready) begin
          wr_nxt       = 1'b1;
          dat_nxt      = shreg[31:24];
          shreg_nxt    = {shreg[23:0], 8'h00};
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (read_x == X_LAST) begin
          if (read_y == Y_LAST) begin
            state_nxt = DONE;
          end else begin
            x_nxt     = '0;
            y_nxt     = read_y + 5'd1;
            state_nxt = FETCH;
          end
        end else begin
          x_nxt     = read_x + 6'd1;
          state_nxt = FETCH;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Self-checking bench: a 2x2 instance with a slow UART model and a default-size
// instance with a fast UART, both checked against a byte-stream reference model.
module tb_frame_dump_ctrl;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int BW = 40;
  localparam int BH = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, btn, start, ubusy, uwr, busy, done;
  logic [5:0]  rx;
  logic [4:0]  ry;
  logic [31:0] rq;
  logic [7:0]  udat;

  logic        b_rst, b_btn, b_start, b_ubusy, b_uwr, b_busy, b_done;
  logic [5:0]  b_rx;
  logic [4:0]  b_ry;
  logic [31:0] b_rq;
  logic [7:0]  b_udat;

  frame_dump_ctrl #(
    .WIDTH(W), .HEIGHT(H), .HOLDOFF_BITS(3), .DEBOUNCE_BITS(3)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .btn_i(btn), .start_i(start),
    .read_x(rx), .read_y(ry), .read_q(rq), .uart_busy_i(ubusy),
    .uart_wr_o(uwr), .uart_dat_o(udat), .busy_o(busy), .done_o(done)
  );

  frame_dump_ctrl #(
    .WIDTH(BW), .HEIGHT(BH), .HOLDOFF_BITS(3), .DEBOUNCE_BITS(3)
  ) dut_big (
    .sys_clk_i(clk), .sys_rst_i(b_rst), .btn_i(b_btn), .start_i(b_start),
    .read_x(b_rx), .read_y(b_ry), .read_q(b_rq), .uart_busy_i(b_ubusy),
    .uart_wr_o(b_uwr), .uart_dat_o(b_udat), .busy_o(b_busy), .done_o(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  b_got_q[$];
  logic [31:0] fb_mem [0:3];
  bit          use_mem   = 1'b0;
  bit          rand_busy = 1'b0;
  int          busy_cnt   = 0;
  int          b_busy_cnt = 0;
  int          cyc = 0, low_run = 0, min_run = 0, busy_viol = 0, adj_viol = 0;
  int          done_cnt = 0, last_strobe_cyc = 0, done_gap = -1, b_done_cnt = 0;
  bit          last_wr = 1'b0;

  function automatic logic [31:0] pix_word(input int x, input int y, input bit mem);
    int idx;
    idx = y * 2 + x;
    if (mem) return (idx >= 0 && idx < 4) ? fb_mem[idx] : 32'hDEAD_BEEF;
    return 32'({2'b00, 5'(y), 1'b0, 6'(x), 16'hBEEF});
  endfunction

  function automatic void build_expected(input int w, input int h, input bit mem);
    logic [31:0] word;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(w));
    exp_q.push_back(8'(h));
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        word = pix_word(x, y, mem);
        for (int b = 3; b >= 0; b--) exp_q.push_back(word[b*8 +: 8]);
      end
    end
  endfunction

  // UART models: busy for a fixed (or random) span starting the cycle after a strobe.
  always @(posedge clk) begin
    if (uwr) busy_cnt <= rand_busy ? int'($urandom_range(0, 12)) : 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (b_uwr) b_busy_cnt <= 1;
    else if (b_busy_cnt != 0) b_busy_cnt <= b_busy_cnt - 1;
  end
  assign ubusy   = (busy_cnt != 0);
  assign b_ubusy = (b_busy_cnt != 0);

  always @(posedge clk) begin
    rq   <= pix_word(int'(rx), int'(ry), use_mem);
    b_rq <= pix_word(int'(b_rx), int'(b_ry), 1'b0);
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      low_run = 0;
      last_wr = 1'b0;
    end else begin
      if (uwr) begin
        got_q.push_back(udat);
        if (low_run < min_run) min_run = low_run;
        if (ubusy) busy_viol++;
        if (last_wr) adj_viol++;
        last_strobe_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_gap = cyc - last_strobe_cyc;
      end
      low_run = (ubusy || uwr) ? 0 : low_run + 1;
      last_wr = uwr;
    end
    if (b_uwr) b_got_q.push_back(b_udat);
    if (b_done) b_done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_records();
    got_q.delete();
    min_run   = 1000000;
    busy_viol = 0;
    adj_viol  = 0;
    done_cnt  = 0;
    done_gap  = -1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; start = 1'b0;
    repeat (3) tick();
    n_checks++; if (uwr !== 1'b0)   begin n_fail++; $display("FAIL reset_uart_wr: got %b expected 0", uwr); end
    n_checks++; if (udat !== 8'h00) begin n_fail++; $display("FAIL reset_uart_dat: got %02h expected 00", udat); end
    n_checks++; if (rx !== 6'd0)    begin n_fail++; $display("FAIL reset_read_x: got %0d expected 0", rx); end
    n_checks++; if (ry !== 5'd0)    begin n_fail++; $display("FAIL reset_read_y: got %0d expected 0", ry); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_full_dump();
    bit ok;
    clear_records();
    build_expected(W, H, 1'b0);
    repeat ($urandom_range(1, 20)) tick();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_rise: got %b expected 1", busy); end
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_done_timeout: got no done expected done"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (done_gap !== 2) begin n_fail++; $display("FAIL full_done_gap: got %0d expected 2", done_gap); end
    n_checks++; if ((min_run >= 7) !== 1'b1) begin n_fail++; $display("FAIL pacing_quiet_run: got %0d expected >=7", min_run); end
    n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL pacing_strobe_while_busy: got %0d expected 0", busy_viol); end
    n_checks++; if (adj_viol !== 0) begin n_fail++; $display("FAIL pacing_adjacent_strobes: got %0d expected 0", adj_viol); end
    repeat (5) tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_random_content();
    bit ok;
    for (int i = 0; i < 4; i++) fb_mem[i] = $urandom;
    use_mem = 1'b1; rand_busy = 1'b1;
    clear_records();
    build_expected(W, H, 1'b1);
    repeat ($urandom_range(1, 10)) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_done_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if ((min_run >= 7) !== 1'b1) begin n_fail++; $display("FAIL rand_quiet_run: got %0d expected >=7", min_run); end
    n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL rand_strobe_while_busy: got %0d expected 0", busy_viol); end
    n_checks++; if (adj_viol !== 0) begin n_fail++; $display("FAIL rand_adjacent_strobes: got %0d expected 0", adj_viol); end
    use_mem = 1'b0; rand_busy = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_debounce();
    bit ok, saw;
    btn = 1'b1; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    btn = 1'b0;
    repeat (5) tick();
    clear_records();
    btn = 1'b1;
    saw = 1'b0;
    repeat (10) begin tick(); if (busy) saw = 1'b1; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL debounce_short_release: got busy expected idle"); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL debounce_short_bytes: got %0d expected 0", got_q.size()); end
    btn = 1'b0;
    repeat (12) tick();
    clear_records();
    build_expected(W, H, 1'b0);
    btn = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8 && !saw; i++) begin tick(); if (busy) saw = 1'b1; end
    n_checks++; if (saw !== 1'b1) begin n_fail++; $display("FAIL debounce_long_release: got idle expected busy"); end
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL debounce_done_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL debounce_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL debounce_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
    end
    btn = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_retrigger();
    bit ok;
    int k;
    clear_records();
    build_expected(W, H, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    k = int'($urandom_range(2, 18));
    for (int i = 0; i < 1000 && got_q.size() < k; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL retrig_done_timeout: got no done expected done"); end
    repeat (40) tick();
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL retrig_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL retrig_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retrig_busy_after: got %b expected 0", busy); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL retrig_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    clear_records();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 1000 && got_q.size() < 11; i++) tick();
    n_checks++; if (got_q.size() !== 11) begin n_fail++; $display("FAIL midrst_reach_byte: got %0d expected 11", got_q.size()); end
    rst = 1'b1; tick();
    n_checks++; if (uwr !== 1'b0)  begin n_fail++; $display("FAIL midrst_uart_wr: got %b expected 0", uwr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (rx !== 6'd0)   begin n_fail++; $display("FAIL midrst_read_x: got %0d expected 0", rx); end
    n_checks++; if (ry !== 5'd0)   begin n_fail++; $display("FAIL midrst_read_y: got %0d expected 0", ry); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (5) tick();
    clear_records();
    build_expected(W, H, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_done_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_default_size();
    bit ok;
    int bad, first_bad;
    b_rst = 1'b0;
    repeat (10) tick();
    b_got_q.delete();
    b_done_cnt = 0;
    build_expected(BW, BH, 1'b0);
    b_start = 1'b1; tick(); b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 70000 && !ok; i++) begin
      tick();
      if (b_done_cnt > 0) ok = 1'b1;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL big_done_timeout: got no done expected done"); end
    n_checks++; if (b_rx !== 6'd39) begin n_fail++; $display("FAIL big_last_read_x: got %0d expected 39", b_rx); end
    n_checks++; if (b_ry !== 5'd29) begin n_fail++; $display("FAIL big_last_read_y: got %0d expected 29", b_ry); end
    n_checks++; if (b_got_q.size() !== 4804) begin n_fail++; $display("FAIL big_count: got %0d expected 4804", b_got_q.size()); end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= b_got_q.size() || b_got_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL big_content: got %0d wrong bytes (first at %0d) expected 0", bad, first_bad); end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; start = 1'b0;
    b_rst = 1'b1; b_btn = 1'b0; b_start = 1'b0;
    test_reset();
    test_full_dump();
    test_random_content();
    test_debounce();
    test_retrigger();
    test_reset_mid_dump();
    test_default_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
